// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared constants and helper functions for the ShiftRows datapath.
//   BYTE_W    : bits per state byte
//   ROWS      : rows in the Rijndael state (always 4)
//   COL_W     : bits per state column
//   shift_off : row rotation amount for a given block width (NB columns)
//   src_col   : column of the input state that feeds output (r, c)
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int BYTE_W = 8;
    localparam int ROWS   = 4;
    localparam int COL_W  = BYTE_W * ROWS;

    // Rijndael row offsets. Wider blocks (NB = 7, 8) use larger rotations on
    // the upper rows so that the columns still diffuse across the whole block.
    function automatic int shift_off(input int nb, input int r);
        int off;
        off = r;
        if (nb == 7) begin
            off = (r == 3) ? 4 : r;
        end else if (nb == 8) begin
            off = (r >= 2) ? r + 1 : r;
        end
        return off;
    endfunction

    // Encrypt rotates each row left by its offset; decrypt rotates it back.
    // The "+ nb" keeps the decrypt index non-negative before the modulo.
    function automatic int src_col(input int nb, input int r, input int c, input logic inv);
        int off;
        off = shift_off(nb, r);
        if (inv) begin
            return (c - off + nb) % nb;
        end
        return (c + off) % nb;
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// ---------------------------------------------------------------------------
// shift_rows_perm
// Purely combinational ShiftRows / InvShiftRows byte permutation.
//   in_data  : state, byte b = 4*c + r at bits [8*b +: 8] (bit 0 = MSB)
//   inv      : 0 = ShiftRows, 1 = InvShiftRows
//   out_data : permuted state, same byte layout
// Every output byte is a two-way mux between its encrypt and decrypt source
// byte; both source indices are elaboration-time constants.
// ---------------------------------------------------------------------------
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [0:32*NB-1] in_data,
    input  logic             inv,
    output logic [0:32*NB-1] out_data
);

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        for (genvar gc = 0; gc < NB; gc++) begin : g_col
            localparam int ENC_SRC = src_col(NB, gi, gc, 1'b0);
            localparam int DEC_SRC = src_col(NB, gi, gc, 1'b1);

            assign out_data[BYTE_W*(ROWS*gc+gi) +: BYTE_W] = inv
                ? in_data[BYTE_W*(ROWS*DEC_SRC+gi) +: BYTE_W]
                : in_data[BYTE_W*(ROWS*ENC_SRC+gi) +: BYTE_W];
        end
    end

endmodule

// File: rtl/shift_rows_pipe.sv
// ---------------------------------------------------------------------------
// shift_rows_pipe
// Registered ShiftRows / InvShiftRows stage with valid/ready handshakes and a
// 2-entry skid buffer, so the round pipeline can stall without bubbles.
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   in_valid / in_ready : input handshake; in_ready is a pure flop output
//   in_data             : state, byte b = 4*c + r at bits [8*b +: 8]
//   in_inv              : 0 = encrypt, 1 = decrypt; used only on the accept cycle
//   in_user             : sideband tag carried with the block
//   out_valid/out_ready : output handshake; data/tag held while stalled
//   out_data, out_user  : permuted state and its tag
// The permutation is applied before storage, so only permuted data is kept
// and in_inv never needs to be registered.
// ---------------------------------------------------------------------------
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB     = 4,
    parameter int USER_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:32*NB-1]  in_data,
    input  logic              in_inv,
    input  logic [USER_W-1:0] in_user,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:32*NB-1]  out_data,
    output logic [USER_W-1:0] out_user
);

    if (NB < 4 || NB > 8) begin : g_bad_nb
        $fatal(1, "shift_rows_pipe: NB must be in 4..8");
    end

    localparam int W = COL_W * NB;

    // State is the pair {m_valid, s_valid}; 2'b01 cannot occur.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic [0:W-1]      perm_data;

    logic              m_valid_q, m_valid_d;
    logic [0:W-1]      m_data_q,  m_data_d;
    logic [USER_W-1:0] m_user_q,  m_user_d;
    logic              s_valid_q, s_valid_d;
    logic [0:W-1]      s_data_q,  s_data_d;
    logic [USER_W-1:0] s_user_q,  s_user_d;

    logic              accept;
    logic              emit;

    shift_rows_perm #(
        .NB (NB)
    ) u_perm (
        .in_data  (in_data),
        .inv      (in_inv),
        .out_data (perm_data)
    );

    // Ready depends only on the skid register, never on out_ready, which
    // breaks the combinational ready chain through the round pipeline.
    assign in_ready  = !s_valid_q;
    assign accept    = in_valid && in_ready;
    assign emit      = m_valid_q && out_ready;

    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;
    assign out_user  = m_user_q;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_user_d  = m_user_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        s_user_d  = s_user_q;

        case ({m_valid_q, s_valid_q})
            ST_EMPTY: begin
                if (accept) begin
                    m_valid_d = 1'b1;
                    m_data_d  = perm_data;
                    m_user_d  = in_user;
                end
            end
            ST_ONE: begin
                if (accept && emit) begin
                    m_data_d  = perm_data;
                    m_user_d  = in_user;
                end else if (accept) begin
                    // Downstream stalled: park the new block behind M.
                    s_valid_d = 1'b1;
                    s_data_d  = perm_data;
                    s_user_d  = in_user;
                end else if (emit) begin
                    m_valid_d = 1'b0;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the drain path is possible.
                if (emit) begin
                    m_data_d  = s_data_q;
                    m_user_d  = s_user_q;
                    s_valid_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_user_q  <= '0;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
            s_user_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_user_q  <= m_user_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            s_user_q  <= s_user_d;
        end
    end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// ---------------------------------------------------------------------------
// tb_shift_rows_pipe
// Self-checking bench: directed FIPS-197 / index-pattern vectors, NB=8
// round trip, random backpressure, full throughput and mid-stream reset.
// A scoreboard queue holds the expected block for every accepted input and is
// popped whenever the NB=4 instance emits.
// ---------------------------------------------------------------------------
module tb_shift_rows_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // NB = 4 instance
    logic         in_valid, in_ready, in_inv, out_valid, out_ready;
    logic [0:127] in_data, out_data;
    logic [3:0]   in_user, out_user;

    // NB = 8 instance
    logic         in_valid_8, in_ready_8, in_inv_8, out_valid_8, out_ready_8;
    logic [0:255] in_data_8, out_data_8;
    logic [0:0]   in_user_8, out_user_8;

    shift_rows_pipe #(.NB(4), .USER_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .in_user   (in_user),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_user  (out_user)
    );

    shift_rows_pipe #(.NB(8), .USER_W(1)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_8),
        .in_ready  (in_ready_8),
        .in_data   (in_data_8),
        .in_inv    (in_inv_8),
        .in_user   (in_user_8),
        .out_valid (out_valid_8),
        .out_ready (out_ready_8),
        .out_data  (out_data_8),
        .out_user  (out_user_8)
    );

    int n_cmp  = 0;
    int n_err  = 0;
    int n_emit = 0;

    typedef struct {
        logic [0:127] data;
        logic [3:0]   user;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: move each input byte to its destination column.
    function automatic logic [0:255] ref_perm(input logic [0:255] d, input logic inv, input int nb);
        logic [0:255] res;
        int offs[4];
        int dst;
        res = '0;
        case (nb)
            7:       offs = '{0, 1, 2, 4};
            8:       offs = '{0, 1, 3, 4};
            default: offs = '{0, 1, 2, 3};
        endcase
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < nb; c++) begin
                dst = inv ? (c + offs[r]) % nb : (c - offs[r] + nb) % nb;
                res[8*(4*dst+r) +: 8] = d[8*(4*c+r) +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [0:127] model4(input logic [0:127] d, input logic inv);
        logic [0:255] t;
        logic [0:255] r;
        t = {d, 128'h0};
        r = ref_perm(t, inv, 4);
        return r[0:127];
    endfunction

    // Scoreboard monitor for the NB=4 instance. At each falling edge the
    // queue size equals the DUT occupancy, so ready/valid are checked too.
    initial begin
        logic         prev_stall;
        logic [0:127] prev_data;
        logic [3:0]   prev_user;
        exp_t         e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_user  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                prev_stall = 1'b0;
            end else begin
                chk("in_ready_vs_occupancy", in_ready, sb.size() < 2);
                chk("out_valid_vs_occupancy", out_valid, sb.size() > 0);
                if (prev_stall) begin
                    chk("hold_data", out_data, prev_data);
                    chk("hold_user", out_user, prev_user);
                end
                if (out_valid && out_ready && sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_data", out_data, e.data);
                    chk("sb_user", out_user, e.user);
                    n_emit++;
                end
                if (in_valid && in_ready) begin
                    e.data = model4(in_data, in_inv);
                    e.user = in_user;
                    sb.push_back(e);
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_user  = out_user;
            end
        end
    end

    // Call at posedge+1: offer one block, it is accepted at the next edge.
    task automatic one_shot4(input logic [0:127] d, input logic inv, input logic [3:0] u,
                             output logic [0:127] res);
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        in_user  = u;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("latency_valid4", out_valid, 1'b1);
        res = out_data;
        $display("txn nb4 in=%h inv=%0d -> out=%h", d, inv, res);
    endtask

    task automatic one_shot8(input logic [0:255] d, input logic inv, output logic [0:255] res);
        in_valid_8 = 1'b1;
        in_data_8  = d;
        in_inv_8   = inv;
        in_user_8  = 1'b1;
        @(posedge clk); #1;
        in_valid_8 = 1'b0;
        chk("latency_valid8", out_valid_8, 1'b1);
        res = out_data_8;
        $display("txn nb8 in=%h inv=%0d -> out=%h", d, inv, res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:127] r4, enc4;
        logic [0:255] idx8, r8, dec8;
        logic [0:127] bp_data[10];
        logic         bp_inv[10];
        int           idx, cyc, emit0;

        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_inv = 1'b0; in_user = '0; out_ready = 1'b1;
        in_valid_8 = 1'b0; in_data_8 = '0; in_inv_8 = 1'b0; in_user_8 = '0; out_ready_8 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_data", out_data, 128'h0);
        chk("rst_out_user", out_user, 4'h0);
        chk("rst_out_valid8", out_valid_8, 1'b0);
        chk("rst_in_ready8", in_ready_8, 1'b1);
        chk("rst_out_data8", out_data_8, 256'h0);
        @(posedge clk); #1;

        // FIPS-197 ShiftRows vector
        one_shot4(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 4'h1, r4);
        chk("fips_enc", r4, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        chk("fips_user", out_user, 4'h1);

        // Index pattern and its inverse
        one_shot4(128'h000102030405060708090a0b0c0d0e0f, 1'b0, 4'h2, enc4);
        chk("idx_enc", enc4, 128'h00050a0f04090e03080d02070c01060b);
        one_shot4(enc4, 1'b1, 4'h3, r4);
        chk("idx_dec", r4, 128'h000102030405060708090a0b0c0d0e0f);

        // NB = 8 round trip
        for (int b = 0; b < 32; b++) begin
            idx8[8*b +: 8] = 8'(b);
        end
        one_shot8(idx8, 1'b0, r8);
        chk("nb8_col0", r8[0:31], 32'h00050e13);
        chk("nb8_enc", r8, ref_perm(idx8, 1'b0, 8));
        one_shot8(idx8, 1'b1, dec8);
        chk("nb8_dec", dec8, ref_perm(idx8, 1'b1, 8));
        one_shot8(dec8, 1'b0, r8);
        chk("nb8_roundtrip", r8, idx8);

        // Backpressure: 10 tagged blocks, random out_ready
        for (int i = 0; i < 10; i++) begin
            bp_data[i] = {$urandom, $urandom, $urandom, $urandom};
            bp_inv[i]  = 1'($urandom_range(0, 1));
        end
        emit0 = n_emit;
        idx = 0;
        cyc = 0;
        while (idx < 10 && cyc < 500) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = 1'b1;
            in_data   = bp_data[idx];
            in_inv    = bp_inv[idx];
            in_user   = 4'(idx);
            @(negedge clk);
            if (in_ready) begin
                $display("txn bp accept user=%0d data=%h inv=%0d", idx, bp_data[idx], bp_inv[idx]);
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("bp_all_accepted", idx, 10);
        cyc = 0;
        while (sb.size() != 0 && cyc < 200) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_drained", sb.size(), 0);
        chk("bp_emit_count", n_emit - emit0, 10);

        // Full throughput: 20 blocks on 20 consecutive cycles
        emit0 = n_emit;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_inv   = 1'(i % 2);
            in_user  = 4'(i);
            @(negedge clk);
            chk("tput_in_ready", in_ready, 1'b1);
            if (i > 0) chk("tput_out_valid", out_valid, 1'b1);
            $display("txn tput beat=%0d data=%h inv=%0d", i, in_data, in_inv);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("tput_last_valid", out_valid, 1'b1);
        @(posedge clk); #1;
        chk("tput_emit_count", n_emit - emit0, 20);

        // Reset mid-stream from FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 128'h11111111222222223333333344444444;
        in_user   = 4'ha;
        in_inv    = 1'b0;
        @(posedge clk); #1;
        in_data   = 128'h55555555666666667777777788888888;
        in_user   = 4'hb;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_out_valid", out_valid, 1'b1);
        @(posedge clk); #1;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        in_user   = 4'hc;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        chk("mrst_out_valid", out_valid, 1'b0);
        chk("mrst_in_ready", in_ready, 1'b1);
        chk("mrst_out_data", out_data, 128'h0);
        chk("mrst_out_user", out_user, 4'h0);
        $display("txn mid-stream reset applied");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mrst_no_emit", out_valid, 1'b0);
        end
        @(posedge clk); #1;

        // Recovery after reset
        one_shot4(128'h0f0e0d0c0b0a09080706050403020100, 1'b1, 4'h5, r4);
        chk("recover_data", r4, model4(128'h0f0e0d0c0b0a09080706050403020100, 1'b1));
        repeat (3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
- Parametrised, registered successor to the combinational AES ShiftRows permutation.
- Supports Rijndael block widths Nb = 4..8 columns and selects ShiftRows or InvShiftRows per transaction.
- Adds valid/ready streaming with a 2-entry skid buffer, so a round pipeline can stall without bubbles.
- Sits between SubBytes and MixColumns stages of the cipher datapath.

Parameters:
- NB, 4, number of 32-bit state columns (legal 4..8; block width W = 32*NB).
- USER_W, 1, width of sideband tag carried alongside each block (legal >= 1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  block accepts input this cycle.
- in_data  in  [0:32*NB-1]  state, byte b = 4*c + r at bits [8*b +: 8] (bit 0 = MSB of byte 0).
- in_inv  in  1  0 = ShiftRows (encrypt), 1 = InvShiftRows (decrypt).
- in_user  in  USER_W  sideband tag, passed through unchanged.
- out_valid  out  1  output block valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  [0:32*NB-1]  permuted state, same byte layout.
- out_user  out  USER_W  tag of the block on out_data.

Behaviour:
- Single clock domain; reset is synchronous and active-high on rst.
- Row offsets off[r]:
  - NB = 4, 5, 6: 0, 1, 2, 3.
  - NB = 7: 0, 1, 2, 4.
  - NB = 8: 0, 1, 3, 4.
- Permutation, per row r and column c:
  - Encrypt: out[r][c] = in[r][(c + off[r]) mod NB].
  - Decrypt: out[r][c] = in[r][(c - off[r] + NB) mod NB].
- The permutation is applied combinationally at the input. Only permuted data and the tag are stored; in_inv is not stored.
- Storage:
  - Main register M (data, user, m_valid) drives the out_* ports.
  - Skid register S (data, user, s_valid).
- in_ready = !s_valid. It is a registered value with no combinational path from out_ready.
- Accept on in_valid && in_ready. Emit on out_valid && out_ready.
- State machine (derived from m_valid/s_valid):
  - EMPTY (0/0): accept -> ONE. Accepted data is visible on out_data the next cycle.
  - ONE (1/0):
    - Accept and emit -> ONE; M is replaced by the new block.
    - Accept without emit -> FULL; new block goes to S.
    - Emit without accept -> EMPTY.
  - FULL (1/1): in_ready = 0.
    - Emit -> ONE; M <= S.
    - No emit -> FULL; hold all state.
- Timing:
  - Latency is 1 cycle from accept to out_valid in EMPTY.
  - Sustained throughput is 1 block/cycle while out_ready = 1.
- out_data and out_user must stay stable while out_valid && !out_ready (AXI-style hold).
- Reset:
  - out_valid = 0, in_ready = 1, m_valid = s_valid = 0.
  - out_data = 0 and out_user = 0; S data is cleared to 0.
  - Reset mid-stream discards both entries. Input offered during the rst cycle is not accepted.
- in_valid while in_ready = 0 is ignored; no data is lost because the source must hold.
- in_inv is sampled only on the accept cycle. Alternating modes on consecutive beats are legal.
- NB outside 4..8 must fail elaboration (generate-time error).

Decomposition:
- Package aes_pkg holds:
  - BYTE_W = 8 and ROWS = 4.
  - Function shift_off(nb, r) returning the row offset.
  - Function src_col(nb, r, c, inv) returning the source column index.
- Sub-module shift_rows_perm: purely combinational.
  - Parameter NB; inputs in_data and inv; output permuted data.
  - Built from generate loops over r and c using aes_pkg functions.
- shift_rows_pipe instantiates shift_rows_perm once and contains only the skid-buffer control.

Test Plan:
- NB=4, encrypt, FIPS-197 vector in d42711aee0bf98f1b8b45de51e415230 -> out d4bf5d30e0b452aeb84111f11e2798e5, out_valid one cycle after accept.
- NB=4, index pattern 000102…0f:
  - Encrypt -> 00050a0f04090e03080d02070c01060b.
  - Feeding that back with in_inv=1 -> 000102…0f.
- NB=8, encrypt, bytes 00..1f -> first output column 00050e13.
  - Same input with in_inv=1, then re-encrypted, returns 00..1f.
- Backpressure: stream 10 tagged blocks (user 0..9) with out_ready random 50%.
  - Every block emerges once, in order, with matching tag.
  - in_ready drops only in FULL.
  - Outputs are held while stalled.
- Full throughput: out_ready=1 and in_valid=1 for 20 cycles -> 20 outputs in consecutive cycles; in_ready stays 1.
- Reset mid-operation: reach FULL, assert rst for 1 cycle -> next cycle out_valid=0, in_ready=1, out_data=0; neither stored block is ever emitted.
